secure_access_gate: RTL

SECURE_ACCESS_GATE -- requirements
Module: secure_access_gate

---
 rtl/secure_access_gate.sv | 139 +++++++++++++
 1 files changed

// File: rtl/secure_access_gate.sv
// Gate that forwards single requests to a secure register only for thread 0 and denies all other threads.
// Optional violation logging (viol_count, viol_last_tid) is enabled with `define SECURE_ACCESS_VIOLATION_LOG_EN.
module secure_access_gate #(
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 4
`ifdef SECURE_ACCESS_VIOLATION_LOG_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [TID_WIDTH-1:0]  req_tid,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  reg_access_en,
  output logic                  reg_wr_en,
  output logic [TID_WIDTH-1:0]  reg_thread_id,
  output logic [DATA_WIDTH-1:0] reg_data_in,
  input  logic [DATA_WIDTH-1:0] reg_data_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic                  viol_clear,
  output logic                  viol_sticky
`ifdef SECURE_ACCESS_VIOLATION_LOG_EN
  ,
  output logic [CNT_WIDTH-1:0]  viol_count,
  output logic [TID_WIDTH-1:0]  viol_last_tid
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, next_state;
  logic                  cap_write;
  logic [TID_WIDTH-1:0]  cap_tid;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  accept, granted, denial, rsp_done;

  assign accept   = req_valid && req_ready;
  assign granted  = (cap_tid == '0);
  assign denial   = (state == ISSUE) && !granted;
  assign rsp_done = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = granted ? WAIT : RESP;
      WAIT:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // req_ready is masked by rst so every output reads 0 while reset is held.
  always_comb begin
    req_ready     = 1'b0;
    reg_access_en = 1'b0;
    reg_wr_en     = 1'b0;
    reg_thread_id = '0;
    reg_data_in   = '0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE:  req_ready = !rst;
      ISSUE: if (granted) begin
        reg_access_en = 1'b1;
        reg_wr_en     = cap_write;
        reg_thread_id = cap_tid;
        reg_data_in   = cap_wdata;
      end
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture; later changes on the req_* inputs cannot reach an in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_tid   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= req_write;
      cap_tid   <= req_tid;
      cap_wdata <= req_wdata;
    end
  end

  // Response registers are cleared on handshake so they read 0 outside RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (denial) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (state == WAIT) begin
      rsp_rdata <= cap_write ? '0 : reg_data_out;
      rsp_err   <= 1'b0;
    end else if (rsp_done) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             viol_sticky <= 1'b0;
    else if (denial)     viol_sticky <= 1'b1;
    else if (viol_clear) viol_sticky <= 1'b0;
  end

`ifdef SECURE_ACCESS_VIOLATION_LOG_EN
  // A denial in the same cycle as a clear restarts the log at one entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_count    <= '0;
      viol_last_tid <= '0;
    end else if (denial) begin
      viol_last_tid <= cap_tid;
      if (viol_clear)             viol_count <= CNT_WIDTH'(1);
      else if (viol_count != '1)  viol_count <= viol_count + 1'b1;
    end else if (viol_clear) begin
      viol_count    <= '0;
      viol_last_tid <= '0;
    end
  end
`endif

endmodule
